// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage pipeline: load-use stall,
// taken-branch squash, registered ALU forwarding selects and perf counters.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rs_i,
  input  logic             id_uses_rt_i,
  input  logic [4:0]       id_rd_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             ex_branch_taken_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } slot_t;

  slot_t ex_slot_reg, mem_slot_reg, wb_slot_reg, ex_slot_next;
  logic  lu;
  logic  stall_inc, flush_inc;
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;
  logic [1:0] fwd_sel [2];

  // Register 0 is hard-wired, so a write to it never creates a dependency.
  function automatic logic slot_writes(input slot_t s, input logic [4:0] r);
    return s.valid && s.regwrite && (s.rd == r) && (r != 5'd0);
  endfunction

  always_comb begin
    lu = id_valid_i && ex_slot_reg.valid && ex_slot_reg.memread &&
         ((id_uses_rs_i && slot_writes(ex_slot_reg, id_rs_i)) ||
          (id_uses_rt_i && slot_writes(ex_slot_reg, id_rt_i)));
  end

  // Reset values double as the safe "hold everything" state while rst_i is low.
  always_comb begin
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b1;
    if (rst_i) begin
      if (ex_branch_taken_i) begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b1;
        idex_bubble_o = 1'b1;
      end else if (lu) begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b1;
      end else begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
      end
    end
  end

  always_comb begin
    ex_slot_next = '0;
    if (id_valid_i && !idex_bubble_o) begin
      ex_slot_next.valid    = 1'b1;
      ex_slot_next.rd       = id_rd_i;
      ex_slot_next.regwrite = id_regwrite_i;
      ex_slot_next.memread  = id_memread_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_slot_reg  <= '0;
      mem_slot_reg <= '0;
      wb_slot_reg  <= '0;
    end else begin
      ex_slot_reg  <= ex_slot_next;
      mem_slot_reg <= ex_slot_reg;
      wb_slot_reg  <= mem_slot_reg;
    end
  end

  // The WB slot is tracked for completeness only; WB->ID is covered by the
  // write-first register file, so nothing downstream consumes it.
  logic wb_unused;
  assign wb_unused = ^wb_slot_reg;

  // One forwarding unit per ALU operand: gi=0 handles rs (A), gi=1 handles rt (B).
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic [4:0] src;
      logic       use_src;
      logic [1:0] fwd_next, fwd_reg;

      assign src     = (gi == 0) ? id_rs_i : id_rt_i;
      assign use_src = (gi == 0) ? id_uses_rs_i : id_uses_rt_i;

      always_comb begin
        fwd_next = 2'b00;
        if (!idex_bubble_o && id_valid_i && use_src) begin
          if (slot_writes(ex_slot_reg, src))
            fwd_next = 2'b01;
          else if (slot_writes(mem_slot_reg, src))
            fwd_next = 2'b10;
        end
      end

      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) fwd_reg <= 2'b00;
        else        fwd_reg <= fwd_next;
      end

      assign fwd_sel[gi] = fwd_reg;
    end
  endgenerate

  assign fwd_a_o = fwd_sel[0];
  assign fwd_b_o = fwd_sel[1];

  assign stall_inc = rst_i && lu && !ex_branch_taken_i;
  assign flush_inc = rst_i && ex_branch_taken_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall_inc && (stall_cnt_reg != {CNT_W{1'b1}}))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (flush_inc && (flush_cnt_reg != {CNT_W{1'b1}}))
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_reg;
  assign flush_cnt_o = flush_cnt_reg;

endmodule
